// File: rtl/img_window_feeder.sv
// Image window feeder: buffers one raster-order image, then streams every
// WIN x WIN window to a downstream classifier and waits for its DONE.
module img_window_feeder #(
    parameter int unsigned IMG_DIM = 28,
    parameter int unsigned WIN     = 5,
    parameter int unsigned PIX_W   = 8
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic [PIX_W-1:0]           PIX_IN,
    input  logic                       PIX_VALID,
    output logic                       PIX_READY,
    input  logic                       CNN_DONE,
    output logic                       START,
    output logic [4:0]                 X,
    output logic [4:0]                 Y,
    output logic [WIN*WIN*PIX_W-1:0]   IMGIN,
    output logic                       WIN_VALID,
    output logic [6:0]                 IMG_CNT
);

    localparam int unsigned NPIX     = IMG_DIM * IMG_DIM;
    localparam int unsigned AW       = (NPIX > 1) ? $clog2(NPIX) : 1;
    localparam int unsigned XY_W     = 5;
    localparam int unsigned CNT_W    = 7;
    localparam int unsigned WIN_BITS = WIN * WIN * PIX_W;

    localparam logic [XY_W-1:0] LAST_POS  = XY_W'(IMG_DIM - WIN);
    localparam logic [AW-1:0]   LAST_ADDR = AW'(NPIX - 1);

    localparam logic [1:0] S_LOAD = 2'd0;
    localparam logic [1:0] S_KICK = 2'd1;
    localparam logic [1:0] S_SCAN = 2'd2;
    localparam logic [1:0] S_WAIT = 2'd3;

    logic [1:0]          state;
    logic [1:0]          state_next;
    logic [AW-1:0]       addr;
    logic [AW-1:0]       addr_next;
    logic [PIX_W-1:0]    buffer [NPIX];
    logic                buf_we;
    logic                last_win;
    logic                load_win;
    logic [XY_W-1:0]     win_x;
    logic [XY_W-1:0]     win_y;
    logic [XY_W-1:0]     x_next;
    logic [XY_W-1:0]     y_next;
    logic                win_valid_next;
    logic                start_next;
    logic                ready_next;
    logic [CNT_W-1:0]    img_cnt_next;
    logic [AW-1:0]       rd_addr;
    logic [WIN_BITS-1:0] win_data;
    logic [WIN_BITS-1:0] imgin_next;

    assign last_win = (X == LAST_POS) && (Y == LAST_POS);

    // Position of the window loaded on the next edge; Y advances fastest and
    // never steps past the final window, keeping every read in range.
    always_comb begin
        win_x = '0;
        win_y = '0;
        if (state == S_SCAN && !last_win) begin
            if (Y == LAST_POS) begin
                win_x = X + XY_W'(1);
                win_y = '0;
            end else begin
                win_x = X;
                win_y = Y + XY_W'(1);
            end
        end
    end

    always_comb begin
        win_data = '0;
        rd_addr  = '0;
        for (int unsigned i = 0; i < WIN; i++) begin
            for (int unsigned j = 0; j < WIN; j++) begin
                rd_addr = AW'((32'(win_x) + i) * IMG_DIM + 32'(win_y) + j);
                win_data[(i*WIN+j)*PIX_W +: PIX_W] = buffer[rd_addr];
            end
        end
    end

    always_comb begin
        state_next     = state;
        addr_next      = addr;
        buf_we         = 1'b0;
        load_win       = 1'b0;
        x_next         = X;
        y_next         = Y;
        win_valid_next = 1'b0;
        img_cnt_next   = IMG_CNT;
        case (state)
            S_LOAD: begin
                if (PIX_VALID && !RST) begin
                    buf_we = 1'b1;
                    if (addr == LAST_ADDR) begin
                        addr_next  = '0;
                        state_next = S_KICK;
                    end else begin
                        addr_next = addr + AW'(1);
                    end
                end
            end
            S_KICK: begin
                state_next     = S_SCAN;
                load_win       = 1'b1;
                x_next         = win_x;
                y_next         = win_y;
                win_valid_next = 1'b1;
            end
            S_SCAN: begin
                if (last_win) begin
                    state_next = S_WAIT;
                    x_next     = '0;
                    y_next     = '0;
                end else begin
                    load_win       = 1'b1;
                    x_next         = win_x;
                    y_next         = win_y;
                    win_valid_next = 1'b1;
                end
            end
            S_WAIT: begin
                if (CNN_DONE) begin
                    img_cnt_next = IMG_CNT + CNT_W'(1);
                    state_next   = S_LOAD;
                end
            end
            default: state_next = S_LOAD;
        endcase
        start_next = (state_next == S_KICK);
        ready_next = (state_next == S_LOAD);
        imgin_next = load_win ? win_data : IMGIN;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= S_LOAD;
            addr      <= '0;
            X         <= '0;
            Y         <= '0;
            WIN_VALID <= 1'b0;
            START     <= 1'b0;
            PIX_READY <= 1'b1;
            IMGIN     <= '0;
            IMG_CNT   <= '0;
        end else begin
            state     <= state_next;
            addr      <= addr_next;
            X         <= x_next;
            Y         <= y_next;
            WIN_VALID <= win_valid_next;
            START     <= start_next;
            PIX_READY <= ready_next;
            IMGIN     <= imgin_next;
            IMG_CNT   <= img_cnt_next;
        end
    end

    // Pixel store is never cleared; the previous image stays until overwritten.
    always_ff @(posedge CLK) begin
        if (buf_we) begin
            buffer[addr] <= PIX_IN;
        end
    end

endmodule

// File: tb/tb_img_window_feeder.sv
// Bench for img_window_feeder: random and patterned images checked against a
// window model built directly from the stored image array.
module tb_img_window_feeder;

    localparam int DIM = 28, WIN = 5, PW = 8, NPIX = 784, ND = 24, NWIN = 576, WW = 200;
    localparam int SDIM = 7, SWIN = 3, SND = 5, SNPIX = 49, SWW = 72;

    logic          clk;
    logic          rst;
    logic [PW-1:0] pix_in;
    logic          pix_valid, pix_ready, cnn_done, start, win_valid;
    logic [4:0]    x, y;
    logic [WW-1:0] imgin;
    logic [6:0]    img_cnt;

    logic          s_rst;
    logic [PW-1:0] s_pix_in;
    logic          s_pix_valid, s_pix_ready, s_done, s_start, s_win_valid;
    logic [4:0]    s_x, s_y;
    logic [SWW-1:0] s_imgin;
    logic [6:0]    s_img_cnt;

    int n_cmp = 0;
    int n_bad = 0;
    logic [7:0] model_img [NPIX];
    logic [7:0] s_img [SNPIX];
    logic [6:0] exp_cnt;

    img_window_feeder dut (
        .CLK(clk), .RST(rst), .PIX_IN(pix_in), .PIX_VALID(pix_valid),
        .PIX_READY(pix_ready), .CNN_DONE(cnn_done), .START(start),
        .X(x), .Y(y), .IMGIN(imgin), .WIN_VALID(win_valid), .IMG_CNT(img_cnt)
    );

    img_window_feeder #(.IMG_DIM(SDIM), .WIN(SWIN), .PIX_W(PW)) dut_small (
        .CLK(clk), .RST(s_rst), .PIX_IN(s_pix_in), .PIX_VALID(s_pix_valid),
        .PIX_READY(s_pix_ready), .CNN_DONE(s_done), .START(s_start),
        .X(s_x), .Y(s_y), .IMGIN(s_imgin), .WIN_VALID(s_win_valid), .IMG_CNT(s_img_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [WW-1:0] exp_win(input int r, input int c);
        logic [WW-1:0] w;
        w = '0;
        for (int i = 0; i < WIN; i++)
            for (int j = 0; j < WIN; j++)
                w[(i*WIN+j)*PW +: PW] = model_img[(r+i)*DIM + c + j];
        return w;
    endfunction

    function automatic logic [SWW-1:0] s_exp_win(input int r, input int c);
        logic [SWW-1:0] w;
        w = '0;
        for (int i = 0; i < SWIN; i++)
            for (int j = 0; j < SWIN; j++)
                w[(i*SWIN+j)*PW +: PW] = s_img[(r+i)*SDIM + c + j];
        return w;
    endfunction

    // mode 0: gap-free, 1: gap then pixel alternating, 2: random gaps
    task automatic load_image(input int mode, output int ready_cnt, output int early, output int slots);
        int k;
        k = 0; slots = 0; ready_cnt = 0; early = 0;
        while (k < NPIX && slots < 8000) begin
            @(negedge clk);
            if (pix_ready === 1'b1) ready_cnt++;
            if (start !== 1'b0) early++;
            if (mode == 0 || (mode == 1 && slots % 2 == 1) || (mode == 2 && $urandom_range(0, 3) != 0)) begin
                pix_valid = 1'b1;
                pix_in    = model_img[k];
                k++;
            end else begin
                pix_valid = 1'b0;
                pix_in    = 8'($urandom);
            end
            slots++;
        end
    endtask

    task automatic scan_collect(input bit noise, output int nstart, output int nwin, output int nbad,
                                output logic [WW-1:0] first_w, output logic [WW-1:0] last_w);
        int ex, ey;
        nstart = 0; nwin = 0; nbad = 0; first_w = '0; last_w = '0;
        for (int c = 0; c < NWIN + 20; c++) begin
            @(negedge clk);
            if (start === 1'b1) nstart++;
            if (win_valid === 1'b1) begin
                ex = nwin / ND;
                ey = nwin % ND;
                if (nwin == 0) first_w = imgin;
                last_w = imgin;
                if (x !== 5'(ex) || y !== 5'(ey) || imgin !== exp_win(ex, ey)) nbad++;
                nwin++;
            end else if (nwin > 0) begin
                break;
            end
            if (noise) begin
                cnn_done  = 1'($urandom);
                pix_valid = 1'($urandom);
                pix_in    = 8'($urandom);
            end else begin
                pix_valid = 1'b0;
            end
        end
        cnn_done  = 1'b0;
        pix_valid = 1'b0;
    endtask

    task automatic release_done(input int hold, output logic rdy_first, output logic [6:0] cnt_first,
                                output logic [6:0] cnt_end);
        cnn_done = 1'b1;
        @(negedge clk);
        rdy_first = pix_ready;
        cnt_first = img_cnt;
        repeat (hold - 1) @(negedge clk);
        cnt_end  = img_cnt;
        cnn_done = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; s_rst = 1'b1;
        pix_valid = 1'b1; pix_in = 8'hAA; cnn_done = 1'b1;
        s_pix_valid = 1'b0; s_pix_in = '0; s_done = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++; if (pix_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready: got %b want 1", pix_ready); end
        n_cmp++; if ({start, win_valid} !== 2'b00) begin n_bad++; $display("FAIL reset_start_valid: got %b want 00", {start, win_valid}); end
        n_cmp++; if ({x, y} !== 10'd0) begin n_bad++; $display("FAIL reset_xy: got %0d,%0d want 0,0", x, y); end
        n_cmp++; if (imgin !== '0) begin n_bad++; $display("FAIL reset_imgin: got %h want 0", imgin); end
        n_cmp++; if (img_cnt !== 7'd0) begin n_bad++; $display("FAIL reset_cnt: got %0d want 0", img_cnt); end
        rst = 1'b0; s_rst = 1'b0; pix_valid = 1'b0; cnn_done = 1'b0;
        exp_cnt = 7'd0;
    endtask

    task automatic test_pattern();
        int rc, early, slots, ns, nw, nb;
        logic [WW-1:0] fw, lw;
        logic rdy;
        logic [6:0] c1, c2;
        for (int k = 0; k < NPIX; k++) model_img[k] = 8'(k);
        load_image(0, rc, early, slots);
        n_cmp++; if (rc !== 784) begin n_bad++; $display("FAIL pattern_load_cycles: got %0d want 784", rc); end
        n_cmp++; if (early !== 0) begin n_bad++; $display("FAIL pattern_early_start: got %0d want 0", early); end
        scan_collect(1'b0, ns, nw, nb, fw, lw);
        n_cmp++; if (ns !== 1) begin n_bad++; $display("FAIL pattern_starts: got %0d want 1", ns); end
        n_cmp++; if (nw !== NWIN) begin n_bad++; $display("FAIL pattern_windows: got %0d want 576", nw); end
        n_cmp++; if (nb !== 0) begin n_bad++; $display("FAIL pattern_window_data: got %0d bad want 0", nb); end
        n_cmp++; if ({fw[47:40], fw[15:8], fw[7:0]} !== 24'h1C0100) begin n_bad++; $display("FAIL pattern_first_bytes: got %h want 1c0100", {fw[47:40], fw[15:8], fw[7:0]}); end
        n_cmp++; if (lw[199:192] !== 8'h0F) begin n_bad++; $display("FAIL pattern_last_byte: got %h want 0f", lw[199:192]); end
        n_cmp++; if ({win_valid, x, y, start, pix_ready} !== 13'd0) begin n_bad++; $display("FAIL wait_outputs: got %b want 0", {win_valid, x, y, start, pix_ready}); end
        n_cmp++; if (imgin !== exp_win(ND - 1, ND - 1)) begin n_bad++; $display("FAIL wait_imgin_hold: got %h want %h", imgin, exp_win(ND - 1, ND - 1)); end
        repeat (2) @(negedge clk);
        n_cmp++; if ({pix_ready, img_cnt} !== {1'b0, exp_cnt}) begin n_bad++; $display("FAIL wait_idle: got %b/%0d want 0/%0d", pix_ready, img_cnt, exp_cnt); end
        release_done(1, rdy, c1, c2);
        exp_cnt++;
        n_cmp++; if ({rdy, c1} !== {1'b1, exp_cnt}) begin n_bad++; $display("FAIL pattern_done: got %b/%0d want 1/%0d", rdy, c1, exp_cnt); end
    endtask

    task automatic test_gaps();
        int rc, early, slots, ns, nw, nb;
        logic [WW-1:0] fw, lw;
        logic rdy;
        logic [6:0] c1, c2;
        load_image(1, rc, early, slots);
        n_cmp++; if (rc !== 1568) begin n_bad++; $display("FAIL gaps_load_cycles: got %0d want 1568", rc); end
        n_cmp++; if (early !== 0) begin n_bad++; $display("FAIL gaps_early_start: got %0d want 0", early); end
        scan_collect(1'b0, ns, nw, nb, fw, lw);
        n_cmp++; if ({ns, nw, nb} !== {32'd1, 32'd576, 32'd0}) begin n_bad++; $display("FAIL gaps_scan: got %0d/%0d/%0d want 1/576/0", ns, nw, nb); end
        release_done(1, rdy, c1, c2);
        exp_cnt++;
        n_cmp++; if ({rdy, c1} !== {1'b1, exp_cnt}) begin n_bad++; $display("FAIL gaps_done: got %b/%0d want 1/%0d", rdy, c1, exp_cnt); end
    endtask

    task automatic test_done_in_scan();
        int rc, early, slots, ns, nw, nb;
        logic [WW-1:0] fw, lw;
        logic rdy;
        logic [6:0] c1, c2;
        for (int k = 0; k < NPIX; k++) model_img[k] = 8'($urandom);
        load_image(2, rc, early, slots);
        n_cmp++; if ({rc, early} !== {slots, 32'd0}) begin n_bad++; $display("FAIL rgap_load: got %0d/%0d want %0d/0", rc, early, slots); end
        scan_collect(1'b1, ns, nw, nb, fw, lw);
        n_cmp++; if ({ns, nw, nb} !== {32'd1, 32'd576, 32'd0}) begin n_bad++; $display("FAIL noisy_scan: got %0d/%0d/%0d want 1/576/0", ns, nw, nb); end
        repeat (2) @(negedge clk);
        n_cmp++; if ({pix_ready, img_cnt} !== {1'b0, exp_cnt}) begin n_bad++; $display("FAIL noisy_wait: got %b/%0d want 0/%0d", pix_ready, img_cnt, exp_cnt); end
        release_done(3, rdy, c1, c2);
        exp_cnt++;
        n_cmp++; if ({rdy, c1, c2} !== {1'b1, exp_cnt, exp_cnt}) begin n_bad++; $display("FAIL held_done: got %b/%0d/%0d want 1/%0d/%0d", rdy, c1, c2, exp_cnt, exp_cnt); end
    endtask

    task automatic test_reset_abort();
        int rc, early, slots, ns, nw, nb, seen;
        logic [WW-1:0] fw, lw;
        logic rdy;
        logic [6:0] c1, c2;
        for (int k = 0; k < NPIX; k++) model_img[k] = 8'($urandom);
        load_image(0, rc, early, slots);
        seen = 0;
        for (int c = 0; c < 200 && seen < 100; c++) begin
            @(negedge clk);
            pix_valid = 1'b0;
            if (win_valid === 1'b1) seen++;
        end
        rst = 1'b1;
        #1;
        n_cmp++; if ({win_valid, x, y, start} !== 12'd0) begin n_bad++; $display("FAIL abort_outputs: got %b want 0", {win_valid, x, y, start}); end
        n_cmp++; if ({pix_ready, img_cnt, imgin} !== {1'b1, 7'd0, {WW{1'b0}}}) begin n_bad++; $display("FAIL abort_state: got %b/%0d want 1/0", pix_ready, img_cnt); end
        exp_cnt = 7'd0;
        @(negedge clk);
        rst = 1'b0;
        repeat (300) begin
            @(negedge clk);
            pix_valid = 1'b1;
            pix_in    = 8'($urandom);
        end
        @(negedge clk);
        rst = 1'b1; pix_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < NPIX; k++) model_img[k] = 8'($urandom);
        load_image(0, rc, early, slots);
        n_cmp++; if ({rc, early} !== {32'd784, 32'd0}) begin n_bad++; $display("FAIL reload_after_abort: got %0d/%0d want 784/0", rc, early); end
        scan_collect(1'b0, ns, nw, nb, fw, lw);
        n_cmp++; if ({ns, nw, nb} !== {32'd1, 32'd576, 32'd0}) begin n_bad++; $display("FAIL reload_scan: got %0d/%0d/%0d want 1/576/0", ns, nw, nb); end
        release_done(1, rdy, c1, c2);
        exp_cnt++;
        n_cmp++; if (c1 !== exp_cnt) begin n_bad++; $display("FAIL reload_cnt: got %0d want %0d", c1, exp_cnt); end
    endtask

    task automatic test_back_to_back();
        int starts, wins, bad_img, bad_cnt, bad_data;
        logic [6:0] s_exp, cnt_at_128;
        bad_img = 0; bad_cnt = 0; bad_data = 0; s_exp = 7'd0; cnt_at_128 = 7'h7F;
        for (int img = 0; img < 130; img++) begin
            for (int k = 0; k < SNPIX; k++) s_img[k] = 8'($urandom);
            for (int k = 0; k < SNPIX; k++) begin
                @(negedge clk);
                s_pix_valid = 1'b1;
                s_pix_in    = s_img[k];
            end
            starts = 0; wins = 0;
            for (int c = 0; c < 40; c++) begin
                @(negedge clk);
                s_pix_valid = 1'b0;
                if (s_start === 1'b1) starts++;
                if (s_win_valid === 1'b1) begin
                    if (s_x !== 5'(wins / SND) || s_y !== 5'(wins % SND) ||
                        s_imgin !== s_exp_win(wins / SND, wins % SND)) bad_data++;
                    wins++;
                end else if (wins > 0) begin
                    break;
                end
            end
            if (starts != 1 || wins != SND * SND) bad_img++;
            s_done = 1'b1;
            @(negedge clk);
            s_done = 1'b0;
            s_exp++;
            if (s_img_cnt !== s_exp) bad_cnt++;
            if (img == 127) cnt_at_128 = s_img_cnt;
        end
        n_cmp++; if (bad_img !== 0) begin n_bad++; $display("FAIL b2b_start_window_counts: got %0d bad images want 0", bad_img); end
        n_cmp++; if (bad_data !== 0) begin n_bad++; $display("FAIL b2b_window_data: got %0d bad windows want 0", bad_data); end
        n_cmp++; if (bad_cnt !== 0) begin n_bad++; $display("FAIL b2b_img_cnt_track: got %0d bad want 0", bad_cnt); end
        n_cmp++; if (cnt_at_128 !== 7'd0) begin n_bad++; $display("FAIL b2b_wrap: got %0d want 0", cnt_at_128); end
        n_cmp++; if (s_img_cnt !== 7'd2) begin n_bad++; $display("FAIL b2b_final_cnt: got %0d want 2", s_img_cnt); end
    endtask

    initial begin
        test_reset();
        test_pattern();
        test_gaps();
        test_done_in_scan();
        test_reset_abort();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/img_window_feeder.md
IMG_WINDOW_FEEDER -- requirements
Module: img_window_feeder

Interface
REQ-001 Parameter IMG_DIM, default 28, SHALL set the square input image side in pixels.
REQ-002 Parameter WIN, default 5, SHALL set the square window side in pixels.
REQ-003 Parameter PIX_W, default 8, SHALL set the bits per pixel.
REQ-004 Port CLK, input, 1, SHALL be the single clock; all state changes occur on its rising edge.
REQ-005 Port RST, input, 1, SHALL be the reset, asynchronous and active-high.
REQ-006 Port PIX_IN, input, PIX_W, SHALL carry one raster-order pixel.
REQ-007 Port PIX_VALID, input, 1, SHALL mark PIX_IN as valid.
REQ-008 Port PIX_READY, output, 1, SHALL indicate the block accepts pixels.
REQ-009 Port CNN_DONE, input, 1, SHALL be the downstream classifier's DONE.
REQ-010 Port START, output, 1, SHALL be the one-cycle start pulse to the classifier.
REQ-011 Port X, output, 5, SHALL be the window top row index.
REQ-012 Port Y, output, 5, SHALL be the window left column index.
REQ-013 Port IMGIN, output, WIN*WIN*PIX_W (200), SHALL carry the current window.
REQ-014 Port WIN_VALID, output, 1, SHALL mark X/Y/IMGIN as a live window.
REQ-015 Port IMG_CNT, output, 7, SHALL count completed images, wrapping 127->0.

Function
REQ-016 FSM states SHALL be LOAD, KICK, SCAN and WAIT, and the block SHALL leave reset in LOAD.
REQ-017 In LOAD, PIX_READY=1; in all other states, PIX_READY=0.
REQ-018 In LOAD, each cycle with PIX_VALID=1 SHALL write PIX_IN to buffer[addr] and increment addr (0..IMG_DIM*IMG_DIM-1).
REQ-019 When PIX_VALID=0 in LOAD, the block SHALL hold buffer and addr unchanged.
REQ-020 On accepting pixel 783, the block SHALL reset addr to 0 and go to KICK next cycle.
REQ-021 Pixels presented outside LOAD SHALL be ignored, and the buffer SHALL be unchanged.
REQ-022 KICK SHALL last exactly 1 cycle with START=1, WIN_VALID=0 and X=Y=0, then go to SCAN.
REQ-023 START SHALL be 0 in every state other than KICK.
REQ-024 SCAN SHALL emit one window per cycle with WIN_VALID=1, giving 24*24=576 consecutive cycles.
REQ-025 Scan order SHALL increment Y fastest; Y=23 wraps to Y=0 with X+1; the last window is X=23, Y=23.
REQ-026 IMGIN[(i*WIN+j)*PIX_W +: PIX_W] SHALL equal buffer[(X+i)*IMG_DIM+(Y+j)] for i,j in 0..4.
REQ-027 X, Y, IMGIN and WIN_VALID SHALL be registered and SHALL change together on the same edge.
REQ-028 After window (23,23), the block SHALL go to WAIT with WIN_VALID=0, X=0, Y=0, and IMGIN holding its last value.
REQ-029 In WAIT, CNN_DONE=1 SHALL increment IMG_CNT and return to LOAD on the next cycle.
REQ-030 CNN_DONE asserted in LOAD, KICK or SCAN SHALL be ignored.
REQ-031 CNN_DONE held high for multiple cycles SHALL increment IMG_CNT only once per image.
REQ-032 Window indices SHALL never exceed IMG_DIM-WIN (23), so no buffer read goes out of range.
REQ-033 The buffer SHALL retain the previous image until overwritten, and no buffer clear is required.

Reset
REQ-034 While RST=1, the block SHALL be in state LOAD with addr=0, START=0, WIN_VALID=0, X=0, Y=0, IMGIN=0 and IMG_CNT=0.
REQ-035 RST asserted mid-LOAD or mid-SCAN SHALL abort immediately, and a new image SHALL load from pixel 0 after RST deasserts.
REQ-036 The buffer contents SHALL NOT be reset.
REQ-037 The first PIX_VALID accepted SHALL be the one at the first rising edge after RST falls.

Verification
REQ-038 Scenario: load pixel p=(r*28+c)&0xFF, one per cycle -> exactly one START pulse 1 cycle after pixel 783, then 576 WIN_VALID cycles in order; window (0,0) IMGIN[7:0]=0x00, IMGIN[15:8]=0x01, IMGIN[47:40]=0x1C; window (23,23) IMGIN[199:192]=(27*28+27)&0xFF=0x0F.
REQ-039 Scenario: PIX_VALID toggled 1/0 every cycle -> LOAD takes 1568 cycles, buffer contents match the gap-free case, and no START fires early.
REQ-040 Scenario: CNN_DONE pulsed during SCAN, then held high 3 cycles in WAIT -> IMG_CNT increments by exactly 1 and PIX_READY=1 the following cycle.
REQ-041 Scenario: RST pulsed at SCAN window 100 -> WIN_VALID=0 and X=Y=0 immediately; the next START comes only after 784 new pixels.
REQ-042 Scenario: 130 back-to-back images -> IMG_CNT wraps 127->0->1->2, and each image produces exactly 576 windows and 1 START.
